// File: rtl/key_tx_fifo_if.sv
// key_tx_fifo_if: keyboard-to-UART character buffer bus.
// Groups the keyboard push side, the transmitter load handshake and the
// debug status outputs. "master" is the environment, "slave" is the buffer.
interface key_tx_fifo_if #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DROP_CNT_WIDTH = 8
);
    logic                      key_valid;
    logic [7:0]                key_data;
    logic                      tx_load_request;
    logic                      tx_load;
    logic [7:0]                tx_data;
    logic                      clear_overflow;
    logic [ADDR_WIDTH:0]       fifo_count;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      overflow;
    logic [DROP_CNT_WIDTH-1:0] drop_count;

    modport master (
        output key_valid, key_data, tx_load_request, clear_overflow,
        input  tx_load, tx_data, fifo_count, fifo_empty, fifo_full,
               overflow, drop_count
    );

    modport slave (
        input  key_valid, key_data, tx_load_request, clear_overflow,
        output tx_load, tx_data, fifo_count, fifo_empty, fifo_full,
               overflow, drop_count
    );
endinterface

// File: rtl/key_tx_fifo.sv
// key_tx_fifo: buffers ASCII bytes from the PS/2 keyboard and drains them to
// the RS-232 transmitter through a load/load_request handshake.
// Optional feature macro: KEY_TX_FIFO_CRLF_EN -- when defined, every pushed
// carriage return (8'h0D) is followed by an automatically pushed 8'h0A.
module key_tx_fifo #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    key_tx_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [7:0]                mem [DEPTH];
    logic [ADDR_WIDTH-1:0]     wr_ptr;
    logic [ADDR_WIDTH-1:0]     rd_ptr;
    logic [ADDR_WIDTH:0]       count;
    logic [ADDR_WIDTH:0]       count_next;
    logic                      empty_q;
    logic                      full_q;
    logic                      overflow_q;
    logic [DROP_CNT_WIDTH-1:0] drop_q;
    logic [DROP_CNT_WIDTH-1:0] drop_base;
    logic [DROP_CNT_WIDTH-1:0] drop_next;
    logic [DROP_CNT_WIDTH:0]   drop_sum;
    logic [7:0]                tx_data_q;
    logic                      pop;
    logic                      push_req;
    logic                      push;
    logic                      key_lost;
    logic [7:0]                push_data;
    logic [1:0]                drop_n;
`ifdef KEY_TX_FIFO_CRLF_EN
    logic                      lf_pending;
`endif

    // Drain FSM next state; pop only from IDLE so each load needs a fresh request.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_q && bus.tx_load_request) begin
                    pop        = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD:    state_next = HOLDOFF;
            HOLDOFF: begin
                if (!bus.tx_load_request) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Push source selection, acceptance and per-cycle drop accounting.
    always_comb begin
`ifdef KEY_TX_FIFO_CRLF_EN
        // A pending LF takes the write slot; a key arriving alongside is lost.
        push_req  = bus.key_valid || lf_pending;
        push_data = lf_pending ? 8'h0A : bus.key_data;
        key_lost  = lf_pending && bus.key_valid;
`else
        push_req  = bus.key_valid;
        push_data = bus.key_data;
        key_lost  = 1'b0;
`endif
        push   = push_req && (!full_q || pop);
        drop_n = {1'b0, push_req && !push} + {1'b0, key_lost};

        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase

        drop_base = bus.clear_overflow ? '0 : drop_q;
        drop_sum  = {1'b0, drop_base} + {{(DROP_CNT_WIDTH-1){1'b0}}, drop_n};
        drop_next = drop_sum[DROP_CNT_WIDTH] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Character storage; contents are discarded on reset by clearing the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointers, fill level, status flags and the registered transmit word.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                tx_data_q <= mem[rd_ptr];
            end
            count      <= count_next;
            empty_q    <= (count_next == '0);
            full_q     <= (count_next == FULL_COUNT);
            overflow_q <= (drop_n != 2'd0) || (overflow_q && !bus.clear_overflow);
            drop_q     <= drop_next;
        end
    end

`ifdef KEY_TX_FIFO_CRLF_EN
    // Arm an LF for the cycle after a carriage return is accepted.
    always_ff @(posedge clk) begin
        if (reset)           lf_pending <= 1'b0;
        else if (lf_pending) lf_pending <= 1'b0;
        else                 lf_pending <= push && (push_data == 8'h0D);
    end
`endif

    assign bus.tx_load    = (state == LOAD);
    assign bus.tx_data    = tx_data_q;
    assign bus.fifo_count = count;
    assign bus.fifo_empty = empty_q;
    assign bus.fifo_full  = full_q;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_key_tx_fifo.sv
// tb_key_tx_fifo: directed and randomized stimulus for key_tx_fifo, checked
// every cycle against a queue-based reference model plus literal expectations.
// Honours KEY_TX_FIFO_CRLF_EN in both the model and the directed tests.
module tb_key_tx_fifo;
    localparam int DEPTH    = 16;
    localparam int DROP_MAX = 255;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    key_tx_fifo_if #(.ADDR_WIDTH(4), .DROP_CNT_WIDTH(8)) bus ();

    key_tx_fifo #(.ADDR_WIDTH(4), .DROP_CNT_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    byte unsigned q[$];
    bit           m_strobe;
    bit           m_need_low;
    logic [7:0]   m_tx_data;
    bit           m_overflow;
    int           m_drop;
    bit           m_lf;
    bit           m_pop;
    bit           m_want;
    bit           m_acc;
    bit           m_lost;
    byte unsigned m_val;
    int           m_drops;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Model update: one step of the specified buffer behaviour per rising edge.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_strobe   = 0;
            m_need_low = 0;
            m_tx_data  = 8'h00;
            m_overflow = 0;
            m_drop     = 0;
            m_lf       = 0;
        end else begin
            m_pop = !m_strobe && !m_need_low && bus.tx_load_request && q.size() > 0;
            if (m_strobe) m_need_low = 1;
            else if (m_need_low && !bus.tx_load_request) m_need_low = 0;
            m_strobe = m_pop;
            m_want   = bus.key_valid;
            m_val    = bus.key_data;
            m_lost   = 0;
            m_acc    = 0;
            m_drops  = 0;
`ifdef KEY_TX_FIFO_CRLF_EN
            if (m_lf) begin
                m_lost = bus.key_valid;
                m_want = 1;
                m_val  = 8'h0A;
            end
`endif
            if (m_pop) m_tx_data = q.pop_front();
            if (m_want) begin
                if (q.size() < DEPTH) begin
                    q.push_back(m_val);
                    m_acc = 1;
                end else begin
                    m_drops++;
                end
            end
            if (m_lost) m_drops++;
`ifdef KEY_TX_FIFO_CRLF_EN
            m_lf = !m_lf && m_acc && (m_val == 8'h0D);
`endif
            if (bus.clear_overflow) begin
                m_overflow = 0;
                m_drop     = 0;
            end
            if (m_drops > 0) begin
                m_overflow = 1;
                m_drop     = m_drop + m_drops;
                if (m_drop > DROP_MAX) m_drop = DROP_MAX;
            end
        end
    end

    // Compare process: all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_tx_load",    32'(bus.tx_load),    32'(m_strobe));
            check("m_tx_data",    32'(bus.tx_data),    32'(m_tx_data));
            check("m_fifo_count", 32'(bus.fifo_count), q.size());
            check("m_fifo_empty", 32'(bus.fifo_empty), 32'(q.size() == 0));
            check("m_fifo_full",  32'(bus.fifo_full),  32'(q.size() == DEPTH));
            check("m_overflow",   32'(bus.overflow),   32'(m_overflow));
            check("m_drop_count", 32'(bus.drop_count), m_drop);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [7:0] d);
        bus.key_valid = 1'b1;
        bus.key_data  = d;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic drain_one(output logic [7:0] d, output bit ok);
        ok = 0;
        d  = 8'h00;
        bus.tx_load_request = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.tx_load) begin
                d  = bus.tx_data;
                ok = 1;
                break;
            end
        end
        bus.tx_load_request = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic expect_drain(input string name, input logic [7:0] exp);
        logic [7:0] d;
        bit ok;
        drain_one(d, ok);
        check({name, "_timeout"}, 32'(ok), 1);
        if (ok) check(name, 32'(d), 32'(exp));
    endtask

    task automatic pulse_clear();
        bus.clear_overflow = 1'b1;
        @(negedge clk);
        bus.clear_overflow = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int loads;
        int kv_rate;
        int rq_rate;
        bus.key_valid       = 1'b0;
        bus.key_data        = 8'h00;
        bus.tx_load_request = 1'b0;
        bus.clear_overflow  = 1'b0;

        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_tx_load",  32'(bus.tx_load),    0);
        check("rst_tx_data",  32'(bus.tx_data),    0);
        check("rst_count",    32'(bus.fifo_count), 0);
        check("rst_empty",    32'(bus.fifo_empty), 1);
        check("rst_full",     32'(bus.fifo_full),  0);
        check("rst_overflow", 32'(bus.overflow),   0);
        check("rst_drops",    32'(bus.drop_count), 0);

        // Single character latency.
        bus.tx_load_request = 1'b1;
        push(8'h41);
        check("lat_no_early_load", 32'(bus.tx_load), 0);
        check("lat_count1",        32'(bus.fifo_count), 1);
        @(negedge clk);
        check("lat_load",   32'(bus.tx_load),    1);
        check("lat_data",   32'(bus.tx_data),    32'h41);
        check("lat_count0", 32'(bus.fifo_count), 0);
        bus.tx_load_request = 1'b0;
        @(negedge clk);
        check("lat_single_pulse", 32'(bus.tx_load), 0);
        @(negedge clk);

        // Fill to full, overflow by one, then drain in order.
        for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
        push(8'h40);
        check("ovf_full",     32'(bus.fifo_full),  1);
        check("ovf_count",    32'(bus.fifo_count), 16);
        check("ovf_overflow", 32'(bus.overflow),   1);
        check("ovf_drops",    32'(bus.drop_count), 1);
        for (int i = 0; i < 16; i++) expect_drain("ovf_order", 8'(8'h30 + i));
        check("ovf_empty", 32'(bus.fifo_empty), 1);

        // Held request gives exactly one load until it drops.
        push(8'h01); push(8'h02); push(8'h03);
        bus.tx_load_request = 1'b1;
        loads = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.tx_load) loads++;
        end
        check("hold_one_load", loads, 1);
        bus.tx_load_request = 1'b0;
        @(negedge clk);
        bus.tx_load_request = 1'b1;
        loads = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.tx_load) begin
                loads++;
                check("hold_second_data", 32'(bus.tx_data), 32'h02);
            end
        end
        check("hold_second_load", loads, 1);
        bus.tx_load_request = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expect_drain("hold_third", 8'h03);

        // Simultaneous push and pop while full.
        pulse_clear();
        check("clr_overflow", 32'(bus.overflow),   0);
        check("clr_drops",    32'(bus.drop_count), 0);
        for (int i = 0; i < 16; i++) push(8'(8'hA0 + i));
        bus.key_valid = 1'b1;
        bus.key_data  = 8'h55;
        bus.tx_load_request = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.tx_load_request = 1'b0;
        check("fullpp_count", 32'(bus.fifo_count), 16);
        check("fullpp_drops", 32'(bus.drop_count), 0);
        check("fullpp_load",  32'(bus.tx_load),    1);
        check("fullpp_data",  32'(bus.tx_data),    32'hA0);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 16; i++)
            expect_drain("fullpp_order", (i == 15) ? 8'h55 : 8'(8'hA1 + i));

        // Pointer wrap under 40 push/pop pairs at full.
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
        for (int j = 0; j < 40; j++) begin
            bus.key_valid = 1'b1;
            bus.key_data  = 8'(8'hC0 + j);
            bus.tx_load_request = 1'b1;
            @(negedge clk);
            bus.key_valid = 1'b0;
            bus.tx_load_request = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
        check("wrap_count", 32'(bus.fifo_count), 16);
        check("wrap_drops", 32'(bus.drop_count), 0);
        for (int i = 0; i < 16; i++) expect_drain("wrap_order", 8'(8'hC0 + 24 + i));

        // Reset with data queued and the FSM in HOLDOFF.
        for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
        bus.tx_load_request = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mrst_pre_count", 32'(bus.fifo_count), 5);
        pulse_reset();
        check("mrst_count",   32'(bus.fifo_count), 0);
        check("mrst_tx_load", 32'(bus.tx_load),    0);
        check("mrst_tx_data", 32'(bus.tx_data),    0);
        check("mrst_empty",   32'(bus.fifo_empty), 1);
        bus.tx_load_request = 1'b0;
        @(negedge clk);
        push(8'h61);
        expect_drain("mrst_after", 8'h61);

        // Drop counter saturation.
        for (int i = 0; i < 16; i++) push(8'h77);
        bus.key_valid = 1'b1;
        bus.key_data  = 8'h78;
        for (int i = 0; i < 300; i++) @(negedge clk);
        bus.key_valid = 1'b0;
        check("sat_drops",    32'(bus.drop_count), DROP_MAX);
        check("sat_overflow", 32'(bus.overflow),   1);
        bus.key_valid = 1'b1;
        bus.clear_overflow = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.clear_overflow = 1'b0;
        check("clr_drop_wins_ovf",   32'(bus.overflow),   1);
        check("clr_drop_wins_count", 32'(bus.drop_count), 1);
        pulse_reset();

`ifdef KEY_TX_FIFO_CRLF_EN
        push(8'h0D);
        @(negedge clk);
        check("crlf_count", 32'(bus.fifo_count), 2);
        expect_drain("crlf_cr", 8'h0D);
        expect_drain("crlf_lf", 8'h0A);
        for (int i = 0; i < 15; i++) push(8'(8'h20 + i));
        push(8'h0D);
        @(negedge clk);
        check("crlf_full_count", 32'(bus.fifo_count), 16);
        check("crlf_full_drops", 32'(bus.drop_count), 1);
        pulse_reset();
`endif

        // Randomized traffic in phases of differing push/request density.
        for (int c = 0; c < 3000; c++) begin
            case (c / 500)
                0:       begin kv_rate = 30; rq_rate = 70; end
                1:       begin kv_rate = 80; rq_rate = 30; end
                2:       begin kv_rate = 50; rq_rate = 50; end
                3:       begin kv_rate = 90; rq_rate = 60; end
                4:       begin kv_rate = 20; rq_rate = 90; end
                default: begin kv_rate = 60; rq_rate = 40; end
            endcase
            bus.key_valid       = ($urandom_range(0, 99) < kv_rate);
            bus.key_data        = ($urandom_range(0, 7) == 0) ? 8'h0D : 8'($urandom);
            bus.tx_load_request = ($urandom_range(0, 99) < rq_rate);
            bus.clear_overflow  = ($urandom_range(0, 99) < 3);
            reset               = ($urandom_range(0, 999) < 3);
            @(negedge clk);
        end
        reset = 1'b0;
        bus.key_valid = 1'b0;
        bus.clear_overflow = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
